// File: rtl/fc_argmax_out.sv
// fc_argmax_out: final classification stage behind the flattened FC layer.
// Captures per-tile, per-channel neuron beats into a buffer. On i_start it
// scans all OUTPUT_NEURONS values in sequence and reports the index and value
// of the signed maximum. The result is held until the host acknowledges it.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   i_data         [H_CIM_TILES][NUM_CHANNELS] neuron values of the current beat
//   i_we           beat write enable (accepted only when idle)
//   i_start        all beats delivered, begin scan (accepted only when idle)
//   i_result_ready consumer accepts the result (used only while valid)
//   o_ready        block idle, writes/start accepted
//   o_valid        result valid
//   o_class        index of the maximum neuron
//   o_max          value of the maximum neuron
module fc_argmax_out #(
  parameter int DATA_SIZE      = 8,
  parameter int H_CIM_TILES    = 2,
  parameter int NUM_CHANNELS   = 2,
  parameter int ELEMS_PER_TILE = 5,
  parameter int OUTPUT_NEURONS = 10,
  parameter int BEATS          = (ELEMS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS,
  parameter int IDX_WIDTH      = (OUTPUT_NEURONS <= 1) ? 1 : $clog2(OUTPUT_NEURONS)
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  input  logic                                                   i_we,
  input  logic                                                   i_start,
  output logic                                                   o_ready,
  output logic                                                   o_valid,
  output logic [IDX_WIDTH-1:0]                                   o_class,
  output logic [DATA_SIZE-1:0]                                   o_max,
  input  logic                                                   i_result_ready
);

  localparam int BEAT_W = (BEATS <= 1) ? 1 : $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [IDX_WIDTH-1:0]  scan_q, scan_d;
  logic [DATA_SIZE-1:0]  run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]  cls_q, cls_d;
  logic [DATA_SIZE-1:0]  max_q, max_d;

  logic [OUTPUT_NEURONS-1:0][DATA_SIZE-1:0] buf_w;
  logic                                     wr_en;

  assign wr_en = (state_q == S_IDLE) && i_we;

  // Each neuron has a fixed (tile, beat, channel) source, so its cell only
  // needs a beat-match compare; lanes past ELEMS_PER_TILE map to no cell.
  for (genvar gn = 0; gn < OUTPUT_NEURONS; gn++) begin : g_cell
    localparam int                TILE      = gn / ELEMS_PER_TILE;
    localparam int                LANE      = gn % ELEMS_PER_TILE;
    localparam int                CH        = LANE % NUM_CHANNELS;
    localparam logic [BEAT_W-1:0] CELL_BEAT = BEAT_W'(LANE / NUM_CHANNELS);

    logic [DATA_SIZE-1:0] cell_q;

    if (TILE < H_CIM_TILES) begin : g_wr
      always_ff @(posedge clk) begin
        if (wr_en && (beat_q == CELL_BEAT)) begin
          cell_q <= i_data[TILE][CH];
        end
      end
    end else begin : g_none
      assign cell_q = '0;
    end

    assign buf_w[gn] = cell_q;
  end

  logic [DATA_SIZE-1:0] cur_val;
  logic                 take_new;
  logic                 scan_last;
  logic [DATA_SIZE-1:0] cand_max;
  logic [IDX_WIDTH-1:0] cand_idx;

  // Strict greater-than keeps the lowest index on ties.
  assign cur_val   = buf_w[scan_q];
  assign take_new  = (scan_q == '0) || ($signed(cur_val) > $signed(run_max_q));
  assign scan_last = (scan_q == IDX_WIDTH'(OUTPUT_NEURONS - 1));
  assign cand_max  = take_new ? cur_val : run_max_q;
  assign cand_idx  = take_new ? scan_q  : run_idx_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    scan_d    = scan_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    cls_d     = cls_q;
    max_d     = max_q;

    case (state_q)
      S_IDLE: begin
        if (i_we) begin
          beat_d = (beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + 1'b1;
        end
        if (i_start) begin
          beat_d  = '0;
          scan_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        run_max_d = cand_max;
        run_idx_d = cand_idx;
        if (scan_last) begin
          // Last compare feeds the output registers directly so the result
          // is visible on the first DONE cycle.
          scan_d  = '0;
          cls_d   = cand_idx;
          max_d   = cand_max;
          state_d = S_DONE;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_DONE: begin
        if (i_result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      scan_q    <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      cls_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      scan_q    <= scan_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      cls_q     <= cls_d;
      max_q     <= max_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_class = cls_q;
  assign o_max   = max_q;

endmodule

// File: tb/tb_fc_argmax_out.sv
module tb_fc_argmax_out;

  localparam int DS = 8;
  localparam int HT = 2;
  localparam int NC = 2;
  localparam int EP = 5;
  localparam int N  = 10;
  localparam int NB = (EP + NC - 1) / NC;
  localparam int IW = (N <= 1) ? 1 : $clog2(N);

  logic                          clk;
  logic                          rst;
  logic [HT-1:0][NC-1:0][DS-1:0] i_data;
  logic                          i_we;
  logic                          i_start;
  logic                          o_ready;
  logic                          o_valid;
  logic [IW-1:0]                 o_class;
  logic [DS-1:0]                 o_max;
  logic                          i_result_ready;

  fc_argmax_out #(
    .DATA_SIZE(DS),
    .H_CIM_TILES(HT),
    .NUM_CHANNELS(NC),
    .ELEMS_PER_TILE(EP),
    .OUTPUT_NEURONS(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_we(i_we),
    .i_start(i_start),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_class(o_class),
    .o_max(o_max),
    .i_result_ready(i_result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_count  = 0;
  int miss_count = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: neuron array, beat position, and a busy/done timeline.
  int mbuf [N];
  int mbeat;
  bit mbusy;
  bit mdone;
  int mcount;
  int exp_cls;
  int exp_max;
  int lane, nidx, best;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mbeat  = 0;
      mbusy  = 0;
      mdone  = 0;
      mcount = 0;
    end else if (mdone) begin
      if (i_result_ready) mdone = 0;
    end else if (mbusy) begin
      mcount--;
      if (mcount == 0) begin
        mbusy = 0;
        mdone = 1;
      end
    end else begin
      if (i_we) begin
        for (int h = 0; h < HT; h++) begin
          for (int c = 0; c < NC; c++) begin
            lane = mbeat * NC + c;
            nidx = h * EP + lane;
            if (lane < EP && nidx < N) mbuf[nidx] = $signed(i_data[h][c]);
          end
        end
        mbeat = (mbeat + 1) % NB;
      end
      if (i_start) begin
        mbeat = 0;
        best  = 0;
        for (int i = 1; i < N; i++) begin
          if (mbuf[i] > mbuf[best]) best = i;
        end
        exp_cls = best;
        exp_max = mbuf[best];
        mbusy   = 1;
        mcount  = N;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ready", int'(o_ready), int'(!(mbusy || mdone)));
      chk("valid", int'(o_valid), int'(mdone));
      if (mdone) begin
        chk("class", int'(o_class), exp_cls);
        chk("max", int'($signed(o_max)), exp_max);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a0, input int a1, input int b0, input int b1, input bit st);
    i_data[0][0] = 8'(a0);
    i_data[0][1] = 8'(a1);
    i_data[1][0] = 8'(b0);
    i_data[1][1] = 8'(b1);
    i_we    = 1'b1;
    i_start = st;
    step();
    i_we    = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic ack();
    i_result_ready = 1'b1;
    step();
    i_result_ready = 1'b0;
    chk("ack_valid", int'(o_valid), 0);
    chk("ack_ready", int'(o_ready), 1);
  endtask

  initial begin
    rst            = 1'b0;
    i_we           = 1'b0;
    i_start        = 1'b0;
    i_result_ready = 1'b0;
    i_data         = '0;
    #2;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_class", int'(o_class), 0);
    chk("rst_max", int'(o_max), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // Image 1: {3,-1,7,2,7,0,-5,6,1,4}; lane 5 of each tile carries 127 and must be dropped.
    beat(3, -1, 0, -5, 0);
    beat(7, 2, 6, 1, 0);
    beat(7, 127, 4, 127, 0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (N - 1) step();
    chk("lat_pre_valid", int'(o_valid), 0);
    chk("lat_pre_ready", int'(o_ready), 0);
    step();
    chk("img1_valid", int'(o_valid), 1);
    chk("img1_class", int'(o_class), 2);
    chk("img1_max", int'($signed(o_max)), 7);
    chk("model_img1", exp_cls, 2);
    repeat (20) step();
    chk("hold_class", int'(o_class), 2);
    chk("hold_max", int'($signed(o_max)), 7);
    ack();

    // Image 2: all negative, max -2 at 9; last beat shares its cycle with start.
    beat(-10, -3, -9, -4, 0);
    beat(-50, -128, -100, -20, 0);
    beat(-7, 127, -2, 127, 1);
    repeat (2) step();
    i_data  = {4{8'd100}};
    i_we    = 1'b1;
    i_start = 1'b1;
    repeat (3) step();
    i_we    = 1'b0;
    i_start = 1'b0;
    repeat (5) step();
    chk("img2_valid", int'(o_valid), 1);
    chk("img2_class", int'(o_class), 9);
    chk("img2_max", int'($signed(o_max)), -2);
    chk("model_img2", exp_max, -2);
    ack();
    step();
    chk("no_rescan_ready", int'(o_ready), 1);

    // Rescan without rewriting: buffer untouched by writes during scan.
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (N) step();
    chk("rescan_class", int'(o_class), 9);
    chk("rescan_max", int'($signed(o_max)), -2);
    ack();

    // Reset mid-scan at i=4.
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", int'(o_ready), 1);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_class", int'(o_class), 0);
    chk("mid_rst_max", int'(o_max), 0);
    step();
    rst = 1'b1;
    step();

    // Image 3: {5,5,-1,0,3,5,2,1,0,-3}; three-way tie on 5 resolves to index 0.
    beat(5, 5, 5, 2, 0);
    beat(-1, 0, 1, 0, 0);
    beat(3, 0, -3, 0, 0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (N - 1) step();
    chk("img3_pre_valid", int'(o_valid), 0);
    step();
    chk("img3_valid", int'(o_valid), 1);
    chk("img3_class", int'(o_class), 0);
    chk("img3_max", int'($signed(o_max)), 5);
    chk("model_img3", exp_cls, 0);
    ack();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
